// File: rtl/mips32_imem_loader.sv
// Framed byte-stream IMem loader; each word is written one cycle after its 4th byte; rx_ready is always 1.
// The optional idle timeout mid-frame is enabled by defining LOADER_TIMEOUT_EN.
module mips32_imem_loader #(
  parameter int         AW          = 10,
  parameter logic [7:0] SYNC        = 8'hA5,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_halt,
  output logic          busy,
  output logic          load_done,
  output logic          load_err
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR_H, S_ADDR_L, S_COUNT, S_DATA, S_CHK} state_t;

  state_t        r_state, w_next;
  logic          w_acc, w_timeout, w_word_end;
  logic [7:0]    r_addr_h, r_chk;
  logic [AW-1:0] r_addr, r_waddr;
  logic [8:0]    r_wcnt;
  logic [1:0]    r_bidx;
  logic [23:0]   r_word;
  logic [31:0]   r_wdata;
  logic          r_we, r_halt, r_done, r_err;

  assign w_acc      = rx_valid && rx_ready;
  assign w_word_end = (r_bidx == 2'd3);

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_idle_cnt;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)
      r_idle_cnt <= '0;
    else if (w_acc || w_timeout || r_state == S_IDLE)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + TW'(1);
  end

  assign w_timeout = (r_state != S_IDLE) && !w_acc && (r_idle_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // Timer absent: constant-false, the loader may wait in any state forever.
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout)
      w_next = S_IDLE;
    else if (w_acc) begin
      case (r_state)
        S_IDLE:   if (rx_data == SYNC) w_next = S_ADDR_H;
        S_ADDR_H: w_next = S_ADDR_L;
        S_ADDR_L: w_next = S_COUNT;
        S_COUNT:  w_next = S_DATA;
        S_DATA:   if (w_word_end && r_wcnt == 9'd1) w_next = S_CHK;
        S_CHK:    w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_ready   = 1'b1;
    busy       = (r_state != S_IDLE);
    imem_we    = r_we;
    imem_addr  = r_waddr;
    imem_wdata = r_wdata;
    core_halt  = r_halt;
    load_done  = r_done;
    load_err   = r_err;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_h <= '0;
      r_chk    <= '0;
      r_addr   <= '0;
      r_waddr  <= '0;
      r_wcnt   <= '0;
      r_bidx   <= '0;
      r_word   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_halt   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_timeout) begin
        r_err  <= 1'b1;
        r_halt <= 1'b1;
        r_bidx <= '0;
      end else if (w_acc) begin
        case (r_state)
          S_IDLE: begin
            if (rx_data == SYNC) begin
              r_done <= 1'b0;
              r_err  <= 1'b0;
              r_halt <= 1'b1;
              r_chk  <= '0;
              r_bidx <= '0;
            end
          end
          S_ADDR_H: begin
            r_addr_h <= rx_data;
            r_chk    <= r_chk ^ rx_data;
          end
          S_ADDR_L: begin
            r_addr <= AW'({r_addr_h, rx_data});
            r_chk  <= r_chk ^ rx_data;
          end
          S_COUNT: begin
            r_wcnt <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            r_chk  <= r_chk ^ rx_data;
          end
          S_DATA: begin
            r_chk  <= r_chk ^ rx_data;
            r_word <= {r_word[15:0], rx_data};
            r_bidx <= r_bidx + 2'd1;
            if (w_word_end) begin
              r_we    <= 1'b1;
              r_wdata <= {r_word, rx_data};
              r_waddr <= r_addr;
              r_addr  <= r_addr + AW'(1);
              r_wcnt  <= r_wcnt - 9'd1;
            end
          end
          S_CHK: begin
            if (rx_data == r_chk) begin
              r_done <= 1'b1;
              r_halt <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/mips32_imem_loader.md
Name: mips32_imem_loader

Overview:
- Byte-stream program loader: the writer side of the pipelined MIPS32 instruction memory.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word into the core's IMem through a single write port.
- Holds the core halted until a frame passes its checksum. This replaces the direct IMem pokes used in simulation with a synthesizable load path.

Parameters:
- AW, 10, IMem word-address width (IMem depth = 2^AW words).
- SYNC, 8'hA5, frame start byte.
- TIMEOUT_CYC, 1024, idle-cycle limit mid-frame (used only with LOADER_TIMEOUT_EN).

Ports:
- clk1  input  1  single clock; the pipeline phase-1 clock.
- rst_n  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader can accept a byte; a transfer occurs when rx_valid && rx_ready at posedge clk1.
- imem_we  output  1  IMem write strobe, one cycle per word.
- imem_addr  output  AW  IMem word address.
- imem_wdata  output  32  instruction word.
- core_halt  output  1  high means the core must not fetch.
- busy  output  1  a frame is in progress (state != IDLE).
- load_done  output  1  last frame completed with a good checksum.
- load_err  output  1  last frame failed (bad checksum or timeout).

Behaviour:
- Reset values (async assert, sync release): state=IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_halt=1, busy=0, load_done=0, load_err=0, checksum=0.
- Frame format: SYNC, ADDR_H, ADDR_L, COUNT, COUNT*4 data bytes (MSB first), CHK.
  - Start word address = {ADDR_H,ADDR_L} truncated to AW bits.
  - COUNT=0 means 256 words.
  - CHK = XOR of ADDR_H, ADDR_L, COUNT and all data bytes.
- FSM transitions (each advances only on an accepted byte):
  - IDLE: SYNC -> ADDR_H. Clear load_done and load_err, set core_halt=1, checksum=0. Any other byte is discarded; stay in IDLE.
  - ADDR_H -> ADDR_L -> COUNT -> DATA. Each byte is XORed into the checksum.
  - DATA: 2-bit byte index shifts bytes into a word register. On the 4th byte:
    - Next cycle: imem_we=1, imem_wdata=word, imem_addr=current address.
    - Address then increments modulo 2^AW (wraps silently).
    - Word counter decrements; when it reaches 0 -> CHK.
  - CHK: byte == checksum -> load_done=1, core_halt=0; else load_err=1, core_halt stays 1. Then -> IDLE.
- Write latency: imem_we asserts exactly one cycle after the 4th data byte is accepted. Writes occur as data arrives; a bad checksum does not undo them, it only keeps the core halted.
- rx_ready is held at 1 in all states. The loader never back-pressures; the registered write does not collide with the next byte's accept.
- A SYNC value inside ADDR/COUNT/DATA/CHK is treated as data, not a restart.
- load_done and load_err are sticky until the next SYNC accepted in IDLE. They are never both 1.
- rst_n low mid-frame: immediate return to reset values, partial word discarded, no further imem_we.
- rx_valid low: no state change, counters hold.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined: a counter of consecutive cycles with no accepted byte runs while busy. On reaching TIMEOUT_CYC:
  - Any pending partial word is dropped.
  - load_err=1, core_halt=1, state -> IDLE.
  - The counter resets on every accepted byte.
- Not defined: no counter logic; the loader waits in any state indefinitely.

Test Plan:
- Reset, then frame A5 00 00 01 00 43 28 00 6A -> one imem_we with addr 0, data 32'h00432800; load_done=1, core_halt=0, load_err=0.
- Frame at addr 0, COUNT=3, words 00432800/04433800/14434800 with correct CHK -> writes to addr 0,1,2 on consecutive word boundaries; load_done=1.
- Same 1-word frame with CHK 6B -> imem_we still pulses at addr 0; load_err=1, load_done=0, core_halt=1.
- Bytes 00 FF 12 in IDLE, then a valid frame -> first three bytes ignored (busy=0, no writes); frame loads normally.
- Frame with ADDR=16'h03FF, COUNT=2, AW=10 -> writes at 10'h3FF then 10'h000.
- rst_n pulsed low after 2 data bytes -> no imem_we, core_halt=1, busy=0. With LOADER_TIMEOUT_EN, TIMEOUT_CYC=16: stall 16 cycles mid-DATA -> load_err=1, state IDLE.
